radix4_booth_mult_sched: RTL and testbench

- Round-robin scheduler and sequencer that shares one radix4_booth_data_path instance among NUM_REQ requesters.
- Accepts one multiply request at a time over valid/ready and registers its operands.
- Drives the datapath's start, en and counter-reset controls, then returns the product with the requester ID over a valid/ready response channel.
- Sits between requester agents and the datapath; the datapath's rst_n is tied to this block's rst_n.

---
 rtl/radix4_booth_mult_sched_if.sv | 23 ++
 rtl/radix4_booth_mult_sched.sv | 107 ++++++++++
 tb/tb_radix4_booth_mult_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/radix4_booth_mult_sched_if.sv
// radix4_booth_mult_sched_if: requester and response handshake bundle for the Booth multiplier scheduler
interface radix4_booth_mult_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_multiplier;
  logic [NUM_REQ*WIDTH-1:0] req_multiplicand;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [2*WIDTH-1:0]       resp_data;
  logic [ID_W-1:0]          resp_id;
  modport master (
    output req_valid, req_multiplier, req_multiplicand, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );
  modport slave (
    input  req_valid, req_multiplier, req_multiplicand, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/radix4_booth_mult_sched.sv
// radix4_booth_mult_sched: round-robin scheduler sequencing one shared radix-4 Booth datapath
module radix4_booth_mult_sched #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  radix4_booth_mult_sched_if.slave   bus,
  output logic                       busy,
  output logic                       err,
  output logic                       dp_start,
  output logic                       dp_en,
  output logic                       dp_rst_cntr_n,
  output logic [WIDTH-1:0]           dp_multiplier,
  output logic [WIDTH-1:0]           dp_multiplicand,
  input  logic                       dp_done,
  input  logic [2*WIDTH-1:0]         dp_result
);
  localparam int NUM_SHIFTS = (WIDTH + 1) / 2;
  localparam int ID_W       = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W      = $clog2(NUM_SHIFTS + 1);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "radix4_booth_mult_sched: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t state, next_state;

  logic [ID_W-1:0]  ptr, grant_idx, id_q;
  logic             grant_valid, accept, timeout, err_set;
  logic [CNT_W-1:0] run_cnt;
  logic [WIDTH-1:0] sel_mr, sel_md;

  // First pass honours the pointer, second pass wraps to the lowest index.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!grant_valid && bus.req_valid[i] && ID_W'(i) >= ptr) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!grant_valid && bus.req_valid[i]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(i);
      end
  end

  always_comb begin
    sel_mr = '0;
    sel_md = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == grant_idx) begin
        sel_mr = bus.req_multiplier[i*WIDTH +: WIDTH];
        sel_md = bus.req_multiplicand[i*WIDTH +: WIDTH];
      end
  end

  assign bus.req_ready = (state == IDLE && rst_n && grant_valid) ? NUM_REQ'(1) << grant_idx : '0;
  assign accept        = |bus.req_ready;
  assign timeout       = state == RUN && !dp_done && run_cnt == CNT_W'(NUM_SHIFTS - 1);
  assign err_set       = timeout || (dp_done && (state == IDLE || state == LOAD));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? LOAD : IDLE;
      LOAD:    next_state = RUN;
      RUN:     next_state = (dp_done || timeout) ? RESP : RUN;
      RESP:    next_state = bus.resp_ready ? IDLE : RESP;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      id_q            <= '0;
      run_cnt         <= '0;
      dp_multiplier   <= '0;
      dp_multiplicand <= '0;
      dp_rst_cntr_n   <= 1'b0;
      err             <= 1'b0;
    end else begin
      state         <= next_state;
      dp_rst_cntr_n <= next_state == LOAD || next_state == RUN;
      run_cnt       <= state == RUN ? run_cnt + CNT_W'(1) : '0;
      err           <= err | err_set;
      if (accept) begin
        id_q            <= grant_idx;
        ptr             <= grant_idx == ID_W'(NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
        dp_multiplier   <= sel_mr;
        dp_multiplicand <= sel_md;
      end
    end
  end

  assign busy           = state != IDLE;
  assign dp_start       = state == LOAD;
  assign dp_en          = state == RUN;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_data  = state == RESP ? dp_result : '0;
  assign bus.resp_id    = state == RESP ? id_q : '0;
endmodule

// File: tb/tb_radix4_booth_mult_sched.sv
// tb_radix4_booth_mult_sched: scoreboard bench with behavioural datapath stubs for WIDTH=8 and WIDTH=5 builds
module tb_radix4_booth_mult_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  radix4_booth_mult_sched_if #(.WIDTH(8), .NUM_REQ(4)) bus ();
  radix4_booth_mult_sched_if #(.WIDTH(5), .NUM_REQ(1)) bus5 ();

  logic        busy, err, dp_start, dp_en, dp_rst, dp_done, kill8, spur8;
  logic [7:0]  dp_mr, dp_md;
  logic [15:0] dp_res;
  logic [3:0]  sc8;

  logic        busy5, err5, dp_start5, dp_en5, dp_rst5, dp_done5, kill5;
  logic [4:0]  dp_mr5, dp_md5;
  logic [9:0]  dp_res5;
  logic [3:0]  sc5;

  radix4_booth_mult_sched #(.WIDTH(8), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err),
    .dp_start(dp_start), .dp_en(dp_en), .dp_rst_cntr_n(dp_rst),
    .dp_multiplier(dp_mr), .dp_multiplicand(dp_md),
    .dp_done(dp_done), .dp_result(dp_res)
  );

  radix4_booth_mult_sched #(.WIDTH(5), .NUM_REQ(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .busy(busy5), .err(err5),
    .dp_start(dp_start5), .dp_en(dp_en5), .dp_rst_cntr_n(dp_rst5),
    .dp_multiplier(dp_mr5), .dp_multiplicand(dp_md5),
    .dp_done(dp_done5), .dp_result(dp_res5)
  );

  // Datapath stand-ins: done on the last of ceil(W/2) enabled steps, product latched at the done edge.
  assign dp_done  = (dp_en && dp_rst && sc8 == 4'd3 && !kill8) || spur8;
  assign dp_done5 = dp_en5 && dp_rst5 && sc5 == 4'd2 && !kill5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc8 <= '0; dp_res <= '0; sc5 <= '0; dp_res5 <= '0;
    end else begin
      sc8 <= !dp_rst ? '0 : dp_en ? sc8 + 4'd1 : sc8;
      sc5 <= !dp_rst5 ? '0 : dp_en5 ? sc5 + 4'd1 : sc5;
      if (dp_done && dp_en) dp_res <= {{8{dp_mr[7]}}, dp_mr} * {{8{dp_md[7]}}, dp_md};
      if (dp_done5 && dp_en5) dp_res5 <= {{5{dp_mr5[4]}}, dp_mr5} * {{5{dp_md5[4]}}, dp_md5};
    end
  end

  int vecs = 0;
  int errs = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_resp: got data %h id %0d, expected none", bus.resp_data, bus.resp_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_data", 32'(bus.resp_data), 32'(mon_e[15:0]));
        chk("resp_id", 32'(bus.resp_id), 32'(mon_e[17:16]));
      end
    end

  task automatic wait_grant(int r, logic [15:0] e);
    int n = 0;
    #1;
    while (bus.req_ready == 4'b0 && n < 50) begin tick(); n++; end
    chk("grant", 32'(bus.req_ready), 32'(1) << r);
    exp_q.push_back({2'(r), e});
    tick();
  endtask

  task automatic issue(int r, logic [7:0] a, logic [7:0] b, logic [15:0] e);
    bus.req_valid[r] = 1'b1;
    bus.req_multiplier[r*8 +: 8] = a;
    bus.req_multiplicand[r*8 +: 8] = b;
    wait_grant(r, e);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid || busy) && n < 200) begin tick(); n++; end
    chk("drain", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus5.req_valid = '0;
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run5(int req_n, logic req_err);
    int n = 1;
    bus5.req_valid = 1'b1;
    #1;
    chk("w5_ready", 32'(bus5.req_ready), 32'd1);
    tick();
    bus5.req_valid = 1'b0;
    while (!bus5.resp_valid && n < 20) begin tick(); n++; end
    chk("w5_latency", n, req_n);
    chk("w5_err", 32'(err5), 32'(req_err));
    if (!req_err) chk("w5_data", 32'(bus5.resp_data), 32'h350);
    chk("w5_id", 32'(bus5.resp_id), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_multiplier = '0;
    bus.req_multiplicand = '0;
    bus.resp_ready = 1'b1;
    bus5.req_valid = 1'b0;
    bus5.req_multiplier = '0;
    bus5.req_multiplicand = '0;
    bus5.resp_ready = 1'b1;
    kill8 = 1'b0; spur8 = 1'b0; kill5 = 1'b0;
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cntr_n", 32'(dp_rst), 32'd0);
    chk("rst_ctrl", {dp_start, dp_en, bus.resp_valid}, 32'd0);
    chk("rst_operands", {dp_mr, dp_md}, 32'd0);
    do_reset();

    // Single requester 2: -7 * 13 = -91
    n = 1;
    issue(2, 8'hF9, 8'd13, 16'hFFA5);
    while (!bus.resp_valid && n < 20) begin tick(); n++; end
    chk("latency", n, 6);
    drain();

    // Round robin with every requester held valid
    do_reset();
    bus.req_multiplier   = {8'hFF, 8'd100, 8'hFE, 8'd3};
    bus.req_multiplicand = {8'hFF, 8'd100, 8'd9,  8'd5};
    bus.req_valid = 4'hF;
    wait_grant(0, 16'h000F);
    wait_grant(1, 16'hFFEE);
    wait_grant(2, 16'h2710);
    wait_grant(3, 16'h0001);
    wait_grant(0, 16'h000F);
    bus.req_valid = '0;
    drain();

    // Operand corners
    issue(1, 8'h80, 8'h80, 16'h4000);
    issue(1, 8'h80, 8'h7F, 16'hC080);
    issue(1, 8'h00, 8'hFF, 16'h0000);
    drain();

    // Response backpressure
    do_reset();
    bus.resp_ready = 1'b0;
    issue(3, 8'd5, 8'hFD, 16'hFFF1);
    bus.req_valid[0] = 1'b1;
    bus.req_multiplier[7:0] = 8'd2;
    bus.req_multiplicand[7:0] = 8'd2;
    n = 0;
    while (!bus.resp_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", 32'(bus.resp_data), 32'hFFF1);
      chk("bp_id", 32'(bus.resp_id), 32'd3);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_cntr_n", 32'(dp_rst), 32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    wait_grant(0, 16'h0004);
    bus.req_valid[0] = 1'b0;
    drain();

    // Reset in the second RUN cycle drops the in-flight request
    do_reset();
    issue(1, 8'd6, 8'd7, 16'h002A);
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    bus.req_valid = 4'b1010;
    bus.req_multiplier[31:24] = 8'hFB;
    bus.req_multiplicand[31:24] = 8'hFA;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ctrl", {dp_start, dp_en, dp_rst, bus.resp_valid}, 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_grant(1, 16'h002A);
    bus.req_valid[1] = 1'b0;
    wait_grant(3, 16'h001E);
    bus.req_valid = '0;
    drain();

    // WIDTH=5, single requester: 11 * -16 = -176
    do_reset();
    bus5.req_multiplier = 5'd11;
    bus5.req_multiplicand = 5'h10;
    run5(5, 1'b0);
    kill5 = 1'b1;
    run5(5, 1'b1);
    kill5 = 1'b0;

    // Missing done forces RESP and sets err
    do_reset();
    kill8 = 1'b1;
    n = 1;
    issue(0, 8'd3, 8'd3, 16'h0000);
    while (!bus.resp_valid && n < 20) begin
      if (n == 5) chk("wd_err_early", 32'(err), 32'd0);
      tick();
      n++;
    end
    chk("wd_latency", n, 6);
    chk("wd_err", 32'(err), 32'd1);
    drain();
    kill8 = 1'b0;

    // Unexpected done while idle
    do_reset();
    chk("spur_err_pre", 32'(err), 32'd0);
    spur8 = 1'b1;
    tick();
    spur8 = 1'b0;
    chk("spur_err", 32'(err), 32'd1);
    chk("spur_busy", 32'(busy), 32'd0);
    tick();
    chk("spur_sticky", 32'(err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
